mips_register_file: RTL and testbench
=====================================

# mips_register_file

Thirty-two-entry, 32-bit general-purpose register file for the single-cycle MIPS datapath. It sits directly upstream of the 32-bit ALU built from the 1-bit slices. It supplies the two source operands (rs, rt) that drive the ALU's a/b inputs, and it accepts the write-back value (ALU result or memory data) at the end of each cycle. It has two combinational read ports and one clocked write port, with register $0 hard-wired to zero.

## Interface
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, register-index width; depth = 2**ADDR_WIDTH
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- read_reg1  input  ADDR_WIDTH  index for port 1 (rs)
- read_reg2  input  ADDR_WIDTH  index for port 2 (rt)
- write_reg  input  ADDR_WIDTH  index written at the clock edge (rd or rt, selected upstream)
- write_data  input  DATA_WIDTH  write-back value
- reg_write  input  1  write enable from main control
- read_data1  output  DATA_WIDTH  contents of register read_reg1 (ALU a operand)
- read_data2  output  DATA_WIDTH  contents of register read_reg2 (ALU b operand / store data)

## Operation
- Storage: registers r1..r31 are DATA_WIDTH flip-flops. r0 has no storage and always reads 0.
- Read ports are purely combinational muxes over current register state, with no clock involvement.
  - read_dataN = 0 when read_regN == 0.
  - Otherwise read_dataN = rN.
- Write happens at a clock edge.
  - Condition: rising clk with rst=0, reg_write=1 and write_reg != 0.
  - Effect: r[write_reg] <= write_data.
  - All other registers hold their value.
- Writes with write_reg == 0 are silently discarded. Subsequent reads of index 0 still return 0.
- There is no write-through bypass. During the cycle a write is pending, a read of the same index returns the old value; the new value is visible only after the edge. This is mandatory: in the single-cycle datapath write_data depends combinationally on read_data via the ALU, so a bypass would create a combinational loop.
- Reset:
  - A rising clk with rst=1 clears r1..r31 to 0.
  - Reset has priority over a simultaneous write: reg_write is ignored on that edge.
- Reset mid-operation: any in-flight write on the reset edge is lost. The next edge with rst=0 writes normally.
- Both read ports may address the same register, including the one being written. Both return identical (old) values.
- X/Z on write_reg while reg_write=0 must not corrupt any register.

## Timing
- Read latency: 0 cycles. The read is combinational from read_regN and register state to read_dataN.
- Write latency: 1 edge. The value is readable immediately after the rising edge on which it is captured.
- Reset values:
  - Before the first reset edge, register contents are undefined, except that index 0 always reads 0.
  - After one rising edge with rst=1, read_data1 = read_data2 = 0 for every index.
- One write per cycle maximum. No stalls, no handshake: reg_write is sampled only at the edge.
- Critical path: register-to-read_data mux (32:1) feeding the ALU carry chain. The read mux is a flat decoder/mux tree; no priority chain is allowed.

## Test plan
- Reset clear:
  - Write 0xDEADBEEF to r5, then assert rst for 1 cycle.
  - Required: read_reg1=5 gives read_data1=0x00000000.
  - Required: scanning all 32 indices returns 0.
- Write/read all:
  - For i=1..31 write 0x1000_0000+i, then read.
  - Required: read_data1 = 0x1000_0000+i on port 1.
  - Required: port 2 reads the reversed index order concurrently, with matching values.
- Zero register:
  - reg_write=1, write_reg=0, write_data=0xFFFFFFFF.
  - Required: read_reg1=read_reg2=0 gives both outputs 0x00000000.
- No bypass:
  - r7 = 0x00000011. In the same cycle set reg_write=1, write_reg=7, write_data=0x00000022, read_reg1=7.
  - Required before the edge: read_data1 = 0x00000011.
  - Required after the edge: read_data1 = 0x00000022.
- Write disabled:
  - reg_write=0, write_reg=9, write_data=0xABCD1234.
  - Required: r9 keeps its prior value 0x00000009.
- Reset vs write collision:
  - rst=1 and reg_write=1, write_reg=3, write_data=0x55AA55AA on the same edge.
  - Required: r3 reads 0x00000000 afterwards.
  - Required: the next edge with rst=0 writing 0x55AA55AA to r3 succeeds.

Source files
------------

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS general-purpose register file: two combinational read ports,
// one clocked write port, r0 hard-wired to zero, synchronous active-high reset.
module mips_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  reg_write,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // r0 has no storage; index 0 simply never matches any entry below.
   logic [DATA_WIDTH-1:0] regs_r [1:DEPTH-1];
   logic [DEPTH-1:1]      we_s;

   // Per-register write enable; reg_write gates first so an unknown index cannot leak through.
   always_comb begin
      we_s = {(DEPTH-1){1'b0}};
      for (int i = 1; i < DEPTH; i++) begin
         if (reg_write == 1'b1) begin
            we_s[i] = (write_reg == ADDR_WIDTH'(i));
         end else begin
            we_s[i] = 1'b0;
         end
      end
   end

   // Register storage: reset clears every entry and takes priority over a same-edge write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < DEPTH; i++) begin
            regs_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (we_s[i]) begin
               regs_r[i] <= write_data;
            end
         end
      end
   end

   // Read port 1: flat AND-OR mux, no bypass from the pending write.
   always_comb begin
      read_data1 = {DATA_WIDTH{1'b0}};
      for (int i = 1; i < DEPTH; i++) begin
         read_data1 = read_data1 |
                      ({DATA_WIDTH{read_reg1 == ADDR_WIDTH'(i)}} & regs_r[i]);
      end
   end

   // Read port 2: identical structure to port 1.
   always_comb begin
      read_data2 = {DATA_WIDTH{1'b0}};
      for (int i = 1; i < DEPTH; i++) begin
         read_data2 = read_data2 |
                      ({DATA_WIDTH{read_reg2 == ADDR_WIDTH'(i)}} & regs_r[i]);
      end
   end

endmodule

// File: tb/tb_mips_register_file.sv
// Directed self-checking bench for mips_register_file with hand-computed expectations.
module tb_mips_register_file;

   logic        clk;
   logic        rst;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        reg_write;
   logic [31:0] read_data1;
   logic [31:0] read_data2;

   int n_checks;
   int n_errors;

   mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [4:0] idx, input logic [31:0] val);
      reg_write  = 1'b1;
      write_reg  = idx;
      write_data = val;
      tick();
      reg_write  = 1'b0;
   endtask

   task automatic read_both(input string tag, input logic [4:0] a, input logic [4:0] b,
                            input logic [31:0] exp1, input logic [31:0] exp2);
      read_reg1 = a;
      read_reg2 = b;
      #1;
      check_value({tag, "_p1"}, read_data1, exp1);
      check_value({tag, "_p2"}, read_data2, exp2);
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b1;
      reg_write  = 1'b0;
      write_reg  = 5'd0;
      write_data = 32'h0000_0000;
      read_reg1  = 5'd0;
      read_reg2  = 5'd0;
      #1;
      read_both("pre_reset_r0", 5'd0, 5'd0, 32'h0000_0000, 32'h0000_0000);

      tick();
      rst = 1'b0;
      read_both("after_reset_r1", 5'd1, 5'd31, 32'h0000_0000, 32'h0000_0000);

      // Reset clear
      do_write(5'd5, 32'hDEAD_BEEF);
      read_both("r5_written", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      read_both("r5_cleared", 5'd5, 5'd0, 32'h0000_0000, 32'h0000_0000);
      for (int i = 0; i < 32; i++) begin
         read_both($sformatf("scan_zero_%0d", i), 5'(i), 5'(31 - i),
                   32'h0000_0000, 32'h0000_0000);
      end

      // Write/read all, port 2 in reverse order
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'h1000_0000 + 32'(i));
      end
      for (int i = 1; i < 32; i++) begin
         read_both($sformatf("all_%0d", i), 5'(i), 5'(32 - i),
                   32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(32 - i));
      end

      // Zero register discards writes
      do_write(5'd0, 32'hFFFF_FFFF);
      read_both("zero_reg", 5'd0, 5'd0, 32'h0000_0000, 32'h0000_0000);

      // No bypass: old value before the edge, new value after
      do_write(5'd7, 32'h0000_0011);
      read_reg1  = 5'd7;
      read_reg2  = 5'd7;
      reg_write  = 1'b1;
      write_reg  = 5'd7;
      write_data = 32'h0000_0022;
      #1;
      check_value("nobypass_before_p1", read_data1, 32'h0000_0011);
      check_value("nobypass_before_p2", read_data2, 32'h0000_0011);
      tick();
      reg_write = 1'b0;
      check_value("nobypass_after_p1", read_data1, 32'h0000_0022);
      check_value("nobypass_after_p2", read_data2, 32'h0000_0022);

      // Write disabled, including an unknown index
      do_write(5'd9, 32'h0000_0009);
      reg_write  = 1'b0;
      write_reg  = 5'd9;
      write_data = 32'hABCD_1234;
      tick();
      read_both("we_off_r9", 5'd9, 5'd8, 32'h0000_0009, 32'h1000_0008);
      write_reg = 5'bxxxxx;
      tick();
      read_both("we_off_xidx", 5'd9, 5'd10, 32'h0000_0009, 32'h1000_000A);
      write_reg = 5'd0;

      // Reset vs write collision
      rst        = 1'b1;
      reg_write  = 1'b1;
      write_reg  = 5'd3;
      write_data = 32'h55AA_55AA;
      tick();
      rst       = 1'b0;
      reg_write = 1'b0;
      read_both("collide_r3", 5'd3, 5'd7, 32'h0000_0000, 32'h0000_0000);
      do_write(5'd3, 32'h55AA_55AA);
      read_both("post_collide_r3", 5'd3, 5'd4, 32'h55AA_55AA, 32'h0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
